// File: rtl/imm_pipe_extender.sv
// RISC-V immediate extractor/extender with a tag sideband; 1-cycle latency, registered outputs.
// Valid/ready backpressure; IMM_PIPE_SKID_EN selects a 2-entry skid buffer with registered in_ready.
module imm_pipe_extender #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      in_instr,
    input  logic [2:0]       in_imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_pipe_extender: XLEN must be 32 or 64");
        end
    endgenerate

    // Indexed by real instruction bit number so the format table reads like the ISA manual.
    logic [31:7]     w_ins;
    logic [31:0]     w_raw;
    logic            w_zext;
    logic            w_ill;
    logic [XLEN-1:0] w_imm;
    logic            w_in_xfer;

    assign w_ins = in_instr;

    always_comb begin
        w_raw  = 32'h0;
        w_zext = 1'b0;
        w_ill  = 1'b0;
        case (in_imm_src)
            3'b000: w_raw = {{20{w_ins[31]}}, w_ins[31:20]};
            3'b001: w_raw = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
            3'b010: w_raw = {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
            3'b011: w_raw = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};
            3'b100: w_raw = {w_ins[31:12], 12'h000};
            3'b101: begin
                w_raw  = {27'h0, w_ins[19:15]};
                w_zext = 1'b1;
            end
            3'b110: begin
                w_raw  = (XLEN == 64) ? {26'h0, w_ins[25:20]} : {27'h0, w_ins[24:20]};
                w_zext = 1'b1;
            end
            default: begin
                w_zext = 1'b1;
                w_ill  = 1'b1;
            end
        endcase
    end

    assign w_imm     = w_zext ? XLEN'(w_raw) : XLEN'($signed(w_raw));
    assign w_in_xfer = in_valid && in_ready;

    logic             r_out_vld;
    logic [XLEN-1:0]  r_out_imm;
    logic [TAG_W-1:0] r_out_tag;
    logic             r_out_ill;

`ifdef IMM_PIPE_SKID_EN
    logic             r_skid_vld;
    logic [XLEN-1:0]  r_skid_imm;
    logic [TAG_W-1:0] r_skid_tag;
    logic             r_skid_ill;
    logic             r_in_rdy;

    // r_in_rdy always mirrors !r_skid_vld, kept as its own flop so in_ready never sees out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld  <= 1'b0;
            r_out_imm  <= '0;
            r_out_tag  <= '0;
            r_out_ill  <= 1'b0;
            r_skid_vld <= 1'b0;
            r_skid_imm <= '0;
            r_skid_tag <= '0;
            r_skid_ill <= 1'b0;
            r_in_rdy   <= 1'b1;
        end else if (flush) begin
            r_out_vld  <= 1'b0;
            r_skid_vld <= 1'b0;
            r_in_rdy   <= 1'b1;
        end else if (r_skid_vld) begin
            if (out_ready) begin
                r_out_imm  <= r_skid_imm;
                r_out_tag  <= r_skid_tag;
                r_out_ill  <= r_skid_ill;
                r_skid_vld <= 1'b0;
                r_in_rdy   <= 1'b1;
            end
        end else if (w_in_xfer) begin
            if (!r_out_vld || out_ready) begin
                r_out_vld <= 1'b1;
                r_out_imm <= w_imm;
                r_out_tag <= in_tag;
                r_out_ill <= w_ill;
            end else begin
                r_skid_vld <= 1'b1;
                r_skid_imm <= w_imm;
                r_skid_tag <= in_tag;
                r_skid_ill <= w_ill;
                r_in_rdy   <= 1'b0;
            end
        end else if (out_ready) begin
            r_out_vld <= 1'b0;
        end
    end

    assign in_ready = r_in_rdy;
`else
    logic w_out_xfer;

    assign w_out_xfer = r_out_vld && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld <= 1'b0;
            r_out_imm <= '0;
            r_out_tag <= '0;
            r_out_ill <= 1'b0;
        end else if (flush) begin
            r_out_vld <= 1'b0;
        end else if (w_in_xfer) begin
            r_out_vld <= 1'b1;
            r_out_imm <= w_imm;
            r_out_tag <= in_tag;
            r_out_ill <= w_ill;
        end else if (w_out_xfer) begin
            r_out_vld <= 1'b0;
        end
    end

    assign in_ready = !r_out_vld || out_ready;
`endif

    assign out_valid   = r_out_vld;
    assign out_imm     = r_out_imm;
    assign out_tag     = r_out_tag;
    assign out_illegal = r_out_ill;

endmodule

// File: tb/tb_imm_pipe_extender.sv
// Directed bench for imm_pipe_extender: format table on XLEN=32 and XLEN=64 instances,
// plus hand sequences for stall, backpressure ordering, flush and asynchronous reset.
module tb_imm_pipe_extender;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [24:0] in_instr;
    logic [2:0]  in_imm_src;
    logic [31:0] in_tag;
    logic        out_ready;

    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_imm, out_tag;
    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64;
    logic [31:0] out_tag64;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    imm_pipe_extender #(.XLEN(32), .TAG_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_imm_src(in_imm_src), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_tag(out_tag), .out_illegal(out_illegal)
    );

    imm_pipe_extender #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr),
        .in_imm_src(in_imm_src), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
        .out_tag(out_tag64), .out_illegal(out_illegal64)
    );

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  src;
        logic [31:0] tag;
        logic [63:0] exp32;
        logic [63:0] exp64;
        logic        ill;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [2:0] src,
                         input logic [31:0] tag);
        in_valid   = v;
        in_instr   = instr[31:7];
        in_imm_src = src;
        in_tag     = tag;
    endtask

    initial begin
        vecs[0]  = '{32'hFFF00093, 3'd0, 32'h100, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        vecs[1]  = '{32'h7FF00000, 3'd0, 32'h101, 64'h7FF, 64'h7FF, 1'b0};
        vecs[2]  = '{32'h02000080, 3'd1, 32'h102, 64'h21, 64'h21, 1'b0};
        vecs[3]  = '{32'hFE000F80, 3'd1, 32'h103, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        vecs[4]  = '{32'hFE000EE3, 3'd2, 32'h104, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        vecs[5]  = '{32'h00000180, 3'd2, 32'h105, 64'h802, 64'h802, 1'b0};
        vecs[6]  = '{32'h800000EF, 3'd3, 32'h106, 64'hFFF00000, 64'hFFFFFFFFFFF00000, 1'b0};
        vecs[7]  = '{32'h00301000, 3'd3, 32'h107, 64'h1802, 64'h1802, 1'b0};
        vecs[8]  = '{32'h80000037, 3'd4, 32'h108, 64'h80000000, 64'hFFFFFFFF80000000, 1'b0};
        vecs[9]  = '{32'h12345037, 3'd4, 32'h109, 64'h12345000, 64'h12345000, 1'b0};
        vecs[10] = '{32'h800F8073, 3'd5, 32'h10A, 64'h1F, 64'h1F, 1'b0};
        vecs[11] = '{32'h83F00013, 3'd6, 32'h10B, 64'h1F, 64'h3F, 1'b0};
        vecs[12] = '{32'hFFFFFFFF, 3'd7, 32'hA5, 64'h0, 64'h0, 1'b1};
        vecs[13] = '{32'h00008000, 3'd5, 32'h10C, 64'h1, 64'h1, 1'b0};

        rst_n = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 3'd0, 32'h0);
        #1;
        chk("reset_out_valid", {63'h0, out_valid}, 64'h0);
        chk("reset_out_imm", {32'h0, out_imm}, 64'h0);
        chk("reset_out_tag", {32'h0, out_tag}, 64'h0);
        chk("reset_out_illegal", {63'h0, out_illegal}, 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_reset", {63'h0, in_ready}, 64'h1);
        chk("in_ready64_after_reset", {63'h0, in_ready64}, 64'h1);

        // Back-to-back table, out_ready=1: each vector appears the cycle after it is offered.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(1'b1, vecs[i].instr, vecs[i].src, vecs[i].tag);
            chk($sformatf("in_ready_v%0d", i), {63'h0, in_ready}, 64'h1);
            @(posedge clk); #1;
            chk($sformatf("out_valid_v%0d", i), {63'h0, out_valid}, 64'h1);
            chk($sformatf("imm32_v%0d", i), {32'h0, out_imm}, vecs[i].exp32);
            chk($sformatf("tag32_v%0d", i), {32'h0, out_tag}, {32'h0, vecs[i].tag});
            chk($sformatf("ill32_v%0d", i), {63'h0, out_illegal}, {63'h0, vecs[i].ill});
            chk($sformatf("out_valid64_v%0d", i), {63'h0, out_valid64}, 64'h1);
            chk($sformatf("imm64_v%0d", i), out_imm64, vecs[i].exp64);
            chk($sformatf("tag64_v%0d", i), {32'h0, out_tag64}, {32'h0, vecs[i].tag});
            chk($sformatf("ill64_v%0d", i), {63'h0, out_illegal64}, {63'h0, vecs[i].ill});
        end

        // Drain: valid drops, data holds the last entry.
        @(negedge clk);
        drive(1'b0, 32'h0, 3'd0, 32'h0);
        @(posedge clk); #1;
        chk("drain_out_valid", {63'h0, out_valid}, 64'h0);
        chk("drain_hold_imm", {32'h0, out_imm}, 64'h1);
        chk("drain_hold_tag", {32'h0, out_tag}, 64'h10C);

        // Stall: output must not move while out_ready=0.
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 32'h12345037, 3'd4, 32'h77);
        @(posedge clk); #1;
        chk("stall_load_tag", {32'h0, out_tag}, 64'h77);
        @(negedge clk);
        drive(1'b1, 32'hFFF00093, 3'd0, 32'h78);
        @(posedge clk); #1;
        chk("stall_hold_valid", {63'h0, out_valid}, 64'h1);
        chk("stall_hold_imm", {32'h0, out_imm}, 64'h12345000);
        chk("stall_hold_tag", {32'h0, out_tag}, 64'h77);
        @(negedge clk);
        drive(1'b0, 32'h0, 3'd0, 32'h0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {63'h0, out_valid}, 64'h0);
        chk("async_rst_imm", {32'h0, out_imm}, 64'h0);
        chk("async_rst_tag", {32'h0, out_tag}, 64'h0);
        chk("async_rst_imm64", out_imm64, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", {63'h0, in_ready}, 64'h1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("post_rst_no_output_%0d", c), {63'h0, out_valid}, 64'h0);
        end

        // Backpressure ordering with tags 1,2,3.
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 32'hFFF00093, 3'd0, 32'h1);
        @(posedge clk); #1;
        chk("bp_tag1", {32'h0, out_tag}, 64'h1);
`ifdef IMM_PIPE_SKID_EN
        chk("bp_in_ready_1", {63'h0, in_ready}, 64'h1);
        @(negedge clk);
        drive(1'b1, 32'hFFF00093, 3'd0, 32'h2);
        @(posedge clk); #1;
        chk("bp_in_ready_2", {63'h0, in_ready}, 64'h0);
        chk("bp_hold_tag1", {32'h0, out_tag}, 64'h1);
        @(negedge clk);
        drive(1'b1, 32'hFFF00093, 3'd0, 32'h3);
        @(posedge clk); #1;
        chk("bp_in_ready_3", {63'h0, in_ready}, 64'h0);
        chk("bp_hold_tag1b", {32'h0, out_tag}, 64'h1);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_emit_tag2", {32'h0, out_tag}, 64'h2);
        chk("bp_in_ready_4", {63'h0, in_ready}, 64'h1);
`else
        chk("bp_in_ready_1", {63'h0, in_ready}, 64'h0);
        @(negedge clk);
        drive(1'b1, 32'hFFF00093, 3'd0, 32'h2);
        @(posedge clk); #1;
        chk("bp_hold_tag1", {32'h0, out_tag}, 64'h1);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_emit_tag2", {32'h0, out_tag}, 64'h2);
        @(negedge clk);
        drive(1'b1, 32'hFFF00093, 3'd0, 32'h3);
`endif
        @(posedge clk); #1;
        chk("bp_emit_tag3", {32'h0, out_tag}, 64'h3);
        chk("bp_valid3", {63'h0, out_valid}, 64'h1);
        @(negedge clk);
        drive(1'b0, 32'h0, 3'd0, 32'h0);
        @(posedge clk); #1;
        chk("bp_drained", {63'h0, out_valid}, 64'h0);

        // Flush with a held entry and a same-cycle offer, under both out_ready values.
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            out_ready = 1'b0;
            drive(1'b1, 32'h7FF00000, 3'd0, 32'h11);
            @(posedge clk); #1;
            chk($sformatf("flush%0d_held", r), {32'h0, out_tag}, 64'h11);
            @(negedge clk);
            out_ready = (r == 1);
            flush = 1'b1;
            drive(1'b1, 32'hFFF00093, 3'd0, 32'h22);
            @(posedge clk); #1;
            chk($sformatf("flush%0d_valid", r), {63'h0, out_valid}, 64'h0);
            @(negedge clk);
            flush = 1'b0;
            out_ready = 1'b1;
            drive(1'b0, 32'h0, 3'd0, 32'h0);
            for (int c = 0; c < 3; c++) begin
                @(posedge clk); #1;
                chk($sformatf("flush%0d_quiet_%0d", r, c), {63'h0, out_valid}, 64'h0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/imm_pipe_extender.md
IMM_PIPE_EXTENDER -- requirements
Module: imm_pipe_extender

Interface
REQ-001 Parameter XLEN, default 32: datapath width; SHALL accept only 32 or 64.
REQ-002 Parameter TAG_W, default 32: width of sideband tag (e.g. PC) carried with each immediate.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  synchronous discard of all held entries.
REQ-006 in_valid  input  1  upstream entry present.
REQ-007 in_ready  output  1  block can accept an entry this cycle.
REQ-008 in_instr  input  25  instruction bits [31:7]; in_instr[k-7] carries bit k.
REQ-009 in_imm_src  input  3  immediate format select.
REQ-010 in_tag  input  TAG_W  sideband tag.
REQ-011 out_valid  output  1  extended immediate present.
REQ-012 out_ready  input  1  downstream accepts.
REQ-013 out_imm  output  XLEN  extended immediate.
REQ-014 out_tag  output  TAG_W  tag paired with out_imm.
REQ-015 out_illegal  output  1  in_imm_src was unsupported.

Function
REQ-016 An input transfer SHALL occur when in_valid && in_ready; an output transfer when out_valid && out_ready.
REQ-017 Formats SHALL be sign-extended from instr bit 31 to XLEN: 000 I {[31:20]}; 001 S {[31:25],[11:7]}; 010 B {[31],[7],[30:25],[11:8],0}; 011 J {[31],[19:12],[20],[30:21],0}; 100 U {[31:12],12'h000}.
REQ-018 Format 101 Z (CSR zimm) SHALL zero-extend instr[19:15]; format 110 SH SHALL zero-extend instr[24:20] when XLEN=32 and instr[25:20] when XLEN=64.
REQ-019 Format 111 SHALL produce out_imm=0 with out_illegal=1; all other formats SHALL set out_illegal=0.
REQ-020 Latency SHALL be exactly one cycle from input transfer to out_valid; no combinational path from in_* to out_*.
REQ-021 Entries SHALL leave in acceptance order; none SHALL be dropped or duplicated except by flush or reset.
REQ-022 out_imm, out_tag, out_illegal SHALL hold stable while out_valid && !out_ready.
REQ-023 While out_valid=0, out_imm/out_tag/out_illegal SHALL hold their last value.
REQ-024 flush SHALL empty all storage so out_valid=0 next cycle; an input transfer in the same cycle SHALL be discarded; flush SHALL override out_ready.
REQ-025 Simultaneous input and output transfer with one entry held SHALL replace it, sustaining one entry per cycle.

Reset
REQ-026 rst_n low SHALL immediately force out_valid=0, out_imm=0, out_tag=0, out_illegal=0, all storage empty, independent of clk.
REQ-027 in_ready SHALL be 1 from the first cycle after rst_n deasserts; reset mid-transfer SHALL discard all entries.

Configuration
REQ-028 Macro IMM_PIPE_SKID_EN defined: a two-entry buffer (output register plus skid register); in_ready SHALL be registered, equal to "skid register empty", with no combinational dependence on out_ready.
REQ-029 IMM_PIPE_SKID_EN undefined: single output register; in_ready SHALL equal !out_valid || out_ready (combinational from out_ready).
REQ-030 Both builds SHALL sustain full throughput when out_ready=1 and satisfy REQ-016..REQ-027 identically.

Verification
REQ-031 XLEN=32, instr 0xFFF00093, src 000 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_illegal=0.
REQ-032 instr 0xFE000EE3, src 010 -> out_imm=0xFFFFFFFC; XLEN=64 instr 0x80000037, src 100 -> out_imm=0xFFFFFFFF80000000.
REQ-033 instr with [19:15]=5'h1F, src 101 -> out_imm=0x1F; src 111 with tag 0xA5 -> out_imm=0, out_illegal=1, out_tag=0xA5.
REQ-034 Skid build, out_ready=0, in_valid=1 with tags 1,2,3 -> tags 1,2 accepted, in_ready=0 after second; out_ready=1 -> tags 1,2,3 emitted in order, one per cycle.
REQ-035 One entry held, flush=1 with in_valid=1 same cycle -> out_valid=0 next cycle, no later output of either entry.
REQ-036 rst_n pulsed low mid-cycle with two entries held -> outputs zero immediately, in_ready=1 the cycle after release.
